// File: rtl/decoder_scan_driver.sv
// N-to-2^N one-hot row decoder with registered outputs and a self-sequencing row scanner.
// Define ROW_MASK_EN to add the row_mask port that lets SCAN mode skip rows.
module decoder_scan_driver #(
    parameter int N     = 3,
    parameter int DWELL = 1000,
    parameter int BLANK = 2,
    localparam int OUTS = 2**N
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ena,
    input  logic            mode,
    input  logic [N-1:0]    sel,
`ifdef ROW_MASK_EN
    input  logic [OUTS-1:0] row_mask,
`endif
    output logic [OUTS-1:0] out,
    output logic [N-1:0]    idx,
    output logic            row_start,
    output logic            frame_done
);
    localparam int MAXV = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW   = $clog2(MAXV + 1);
    localparam logic [CW-1:0] DW1 = CW'(DWELL - 1);
    localparam logic [CW-1:0] BL1 = CW'((BLANK > 0) ? BLANK - 1 : 0);

    typedef enum logic [1:0] {IDLE, ON, GAP} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [OUTS-1:0] rmask;
    logic [N-1:0]    nrow;
    logic            last_row;

`ifdef ROW_MASK_EN
    assign rmask = row_mask;
`else
    assign rmask = '1;
`endif

    function automatic logic [OUTS-1:0] onehot(input logic [N-1:0] i);
        logic [OUTS-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Nearest set mask bit above cur, wrapping; returns cur when it is the only one.
    function automatic logic [N-1:0] next_row(input logic [N-1:0] cur, input logic [OUTS-1:0] m);
        logic [N-1:0] r, j;
        r = cur;
        for (int k = OUTS - 1; k >= 1; k--) begin
            j = cur + N'(k);
            if (m[j]) r = j;
        end
        return r;
    endfunction

    // Starting from all-ones makes the wrap land on the lowest enabled row.
    assign nrow     = (state == IDLE) ? next_row({N{1'b1}}, rmask) : next_row(idx, rmask);
    assign last_row = ((rmask >> idx) >> 1) == '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out        <= '0;
            idx        <= '0;
            row_start  <= 1'b0;
            frame_done <= 1'b0;
            state      <= IDLE;
            cnt        <= '0;
        end else begin
            row_start  <= 1'b0;
            frame_done <= 1'b0;
            if (!ena) begin
                out   <= '0;
                state <= IDLE;
                cnt   <= '0;
            end else if (!mode) begin
                out       <= onehot(sel);
                idx       <= sel;
                row_start <= (sel != idx) || (out == '0);
                state     <= IDLE;
                cnt       <= '0;
            end else begin
                if (state == ON && cnt == '0)
                    frame_done <= last_row;
                if (state == IDLE || (cnt == '0 && (state == GAP || BLANK == 0))) begin
                    if (rmask == '0) begin
                        state <= IDLE;
                        out   <= '0;
                        cnt   <= '0;
                    end else begin
                        state     <= ON;
                        idx       <= nrow;
                        out       <= onehot(nrow);
                        row_start <= 1'b1;
                        cnt       <= DW1;
                    end
                end else if (cnt == '0) begin
                    state <= GAP;
                    out   <= '0;
                    cnt   <= BL1;
                end else begin
                    cnt <= cnt - CW'(1);
                end
            end
        end
    end
endmodule
